dma_mc_ctrl: RTL and testbench

DMA_MC_CTRL -- requirements
Module: dma_mc_ctrl

---
 rtl/dma_mc_ctrl_if.sv | 38 +++
 rtl/dma_mc_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_dma_mc_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_mc_ctrl_if.sv
// Register-write, burst-request, completion, descriptor-fetch and interrupt signals of dma_mc_ctrl.
// The master modport is the environment side; slave is the controller side.
interface dma_mc_ctrl_if #(parameter int NCH = 4);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic            wen;
  logic [CW-1:0]   wch;
  logic [2:0]      waddr;
  logic [31:0]     wdata;

  logic            req_valid;
  logic            req_ready;
  logic [CW-1:0]   req_ch;
  logic [31:0]     req_src;
  logic [31:0]     req_dst;
  logic [3:0]      req_len;

  logic            done_valid;
  logic [CW-1:0]   done_ch;

  logic            fetch_valid;
  logic            fetch_ready;
  logic [CW-1:0]   fetch_ch;
  logic [31:0]     fetch_addr;

  logic [NCH-1:0]  irq;
  logic [NCH-1:0]  irq_clr;

  modport master (
    output wen, wch, waddr, wdata, req_ready, done_valid, done_ch, fetch_ready, irq_clr,
    input  req_valid, req_ch, req_src, req_dst, req_len, fetch_valid, fetch_ch, fetch_addr, irq
  );

  modport slave (
    input  wen, wch, waddr, wdata, req_ready, done_valid, done_ch, fetch_ready, irq_clr,
    output req_valid, req_ch, req_src, req_dst, req_len, fetch_valid, fetch_ch, fetch_addr, irq
  );
endinterface

// File: rtl/dma_mc_ctrl.sv
// Multi-channel DMA burst scheduler: round-robin burst requests split at MAX_BEATS and BOUND,
// descriptor-chain fetch requests and per-channel completion interrupts.
module dma_mc_ctrl #(
  parameter int NCH       = 4,
  parameter int MAX_BEATS = 16,
  parameter int BOUND     = 64
) (
  input  logic         clk,
  input  logic         rst,
  dma_mc_ctrl_if.slave bus
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {IDLE, ARMED, BUSY, FETCH, DONE} st_t;

  st_t            st  [NCH];
  logic [31:0]    src [NCH];
  logic [31:0]    dst [NCH];
  logic [31:0]    len [NCH];
  logic [31:0]    nxt [NCH];
  logic [NCH-1:0] eoc;
  logic [NCH-1:0] fetched;
  logic [NCH-1:0] irq;
  logic [CW-1:0]  rr;

  logic           req_valid;
  logic [CW-1:0]  req_ch;
  logic [31:0]    req_src;
  logic [31:0]    req_dst;
  logic [3:0]     req_len;

  logic [NCH-1:0] abort_hit;
  logic           gnt_vld;
  logic [CW-1:0]  gnt;
  logic [4:0]     gnt_beats;
  logic           hs;
  logic [31:0]    req_beats;
  logic [31:0]    req_bytes;
  logic           fetch_pend;
  logic [CW-1:0]  fetch_sel;

  function automatic logic [4:0] calc_beats(input logic [31:0] s, input logic [31:0] d,
                                            input logic [31:0] l);
    logic [31:0] mask;
    logic [31:0] rs;
    logic [31:0] rd;
    logic [4:0]  b;
    mask = 32'(BOUND - 1);
    rs   = (32'(BOUND) - (s & mask)) >> 2;
    rd   = (32'(BOUND) - (d & mask)) >> 2;
    b    = 5'(MAX_BEATS);
    if (l  < 32'(b)) b = l[4:0];
    if (rs < 32'(b)) b = rs[4:0];
    if (rd < 32'(b)) b = rd[4:0];
    return b;
  endfunction

  always_comb begin
    abort_hit = '0;
    for (int i = 0; i < NCH; i++)
      abort_hit[i] = bus.wen && (bus.waddr == 3'd6) && (bus.wch == CW'(i));
  end

  // Search starts at rr, the channel after the last grant; a channel being aborted is skipped.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!gnt_vld && st[(int'(rr) + k) % NCH] == ARMED && !abort_hit[(int'(rr) + k) % NCH]) begin
        gnt_vld = 1'b1;
        gnt     = CW'((int'(rr) + k) % NCH);
      end
    end
  end

  assign gnt_beats = calc_beats(src[gnt], dst[gnt], len[gnt]);
  assign hs        = req_valid && bus.req_ready && !abort_hit[req_ch];
  assign req_beats = {28'd0, req_len} + 32'd1;
  assign req_bytes = req_beats << 2;

  always_comb begin
    fetch_pend = 1'b0;
    fetch_sel  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (st[i] == FETCH && !fetched[i]) begin
        fetch_pend = 1'b1;
        fetch_sel  = CW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        st[i]  <= IDLE;
        src[i] <= '0;
        dst[i] <= '0;
        len[i] <= '0;
        nxt[i] <= '0;
      end
      eoc       <= '0;
      fetched   <= '0;
      irq       <= '0;
      rr        <= '0;
      req_valid <= 1'b0;
      req_ch    <= '0;
      req_src   <= '0;
      req_dst   <= '0;
      req_len   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        // Clear comes first so any set later in this iteration wins.
        if (bus.irq_clr[i]) begin
          irq[i] <= 1'b0;
          if (st[i] == DONE) st[i] <= IDLE;
        end
        if (bus.done_valid && bus.done_ch == CW'(i) && st[i] == BUSY) begin
          if (len[i] != '0) begin
            st[i] <= ARMED;
          end else if (eoc[i]) begin
            st[i]  <= DONE;
            irq[i] <= 1'b1;
          end else begin
            st[i]      <= FETCH;
            fetched[i] <= 1'b0;
          end
        end
        if (hs && req_ch == CW'(i)) begin
          src[i] <= src[i] + req_bytes;
          dst[i] <= dst[i] + req_bytes;
          len[i] <= len[i] - req_beats;
          st[i]  <= BUSY;
        end
        if (fetch_pend && bus.fetch_ready && fetch_sel == CW'(i))
          fetched[i] <= 1'b1;
        if (bus.wen && bus.wch == CW'(i)) begin
          case (bus.waddr)
            3'd0: if (st[i] != ARMED && st[i] != BUSY) src[i] <= bus.wdata;
            3'd1: if (st[i] != ARMED && st[i] != BUSY) dst[i] <= bus.wdata;
            3'd2: if (st[i] != ARMED && st[i] != BUSY) len[i] <= bus.wdata;
            3'd3: if (st[i] != ARMED && st[i] != BUSY) nxt[i] <= bus.wdata;
            3'd4: if (st[i] != ARMED && st[i] != BUSY) eoc[i] <= bus.wdata[0];
            3'd5: begin
              if (st[i] == IDLE || st[i] == FETCH) begin
                fetched[i] <= 1'b0;
                if (len[i] != '0) begin
                  st[i] <= ARMED;
                end else if (eoc[i]) begin
                  st[i]  <= DONE;
                  irq[i] <= 1'b1;
                end else begin
                  st[i] <= FETCH;
                end
              end
            end
            3'd6: begin
              st[i]      <= IDLE;
              irq[i]     <= 1'b0;
              fetched[i] <= 1'b0;
            end
            default: ;
          endcase
        end
      end

      // Request fields are latched at grant and held until accepted or aborted.
      if (req_valid) begin
        if (bus.req_ready || abort_hit[req_ch]) req_valid <= 1'b0;
      end else if (gnt_vld) begin
        req_valid <= 1'b1;
        req_ch    <= gnt;
        req_src   <= src[gnt];
        req_dst   <= dst[gnt];
        req_len   <= 4'(gnt_beats - 5'd1);
        rr        <= CW'((int'(gnt) + 1) % NCH);
      end
    end
  end

  assign bus.req_valid   = req_valid;
  assign bus.req_ch      = req_ch;
  assign bus.req_src     = req_src;
  assign bus.req_dst     = req_dst;
  assign bus.req_len     = req_len;
  assign bus.fetch_valid = fetch_pend;
  assign bus.fetch_ch    = fetch_sel;
  assign bus.fetch_addr  = nxt[fetch_sel];
  assign bus.irq         = irq;
endmodule

// File: tb/tb_dma_mc_ctrl.sv
// Bench for dma_mc_ctrl: directed scenarios plus randomized traffic scored against a
// transaction-level channel model (registers, state per channel, burst-size formula).
module tb_dma_mc_ctrl;
  localparam int NCH = 4, MAXB = 16, BOUND = 64;
  localparam int S_IDLE = 0, S_ARMED = 1, S_BUSY = 2, S_FETCH = 3, S_DONE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dma_mc_ctrl_if #(.NCH(NCH)) bus ();
  dma_mc_ctrl #(.NCH(NCH), .MAX_BEATS(MAXB), .BOUND(BOUND)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  logic [31:0] m_src [NCH];
  logic [31:0] m_dst [NCH];
  logic [31:0] m_len [NCH];
  logic [31:0] m_nxt [NCH];
  int          m_st  [NCH];
  bit          m_eoc [NCH];
  bit          m_irq [NCH];
  bit          m_fet [NCH];

  typedef struct { int ch; int due; } pend_t;
  pend_t       pend [$];
  int          log_ch [$];
  int          log_len [$];
  logic [31:0] log_src [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_src[i] = 0; m_dst[i] = 0; m_len[i] = 0; m_nxt[i] = 0;
      m_st[i] = S_IDLE; m_eoc[i] = 0; m_irq[i] = 0; m_fet[i] = 0;
    end
  endfunction

  function automatic logic [NCH-1:0] irq_vec();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_irq[i];
    return v;
  endfunction

  function automatic int exp_beats(int ch);
    int b, rs, rd;
    b  = MAXB;
    rs = (BOUND - int'(m_src[ch] % BOUND)) / 4;
    rd = (BOUND - int'(m_dst[ch] % BOUND)) / 4;
    if (m_len[ch] < 32'(b)) b = int'(m_len[ch]);
    if (rs < b) b = rs;
    if (rd < b) b = rd;
    return b;
  endfunction

  function automatic void block_or_rearm(int ch);
    m_fet[ch] = 0;
    if (m_len[ch] != 0) m_st[ch] = S_ARMED;
    else if (m_eoc[ch]) begin m_st[ch] = S_DONE; m_irq[ch] = 1; end
    else m_st[ch] = S_FETCH;
  endfunction

  function automatic void model_write(int ch, int a, logic [31:0] d);
    bit locked;
    locked = (m_st[ch] == S_ARMED) || (m_st[ch] == S_BUSY);
    case (a)
      0: if (!locked) m_src[ch] = d;
      1: if (!locked) m_dst[ch] = d;
      2: if (!locked) m_len[ch] = d;
      3: if (!locked) m_nxt[ch] = d;
      4: if (!locked) m_eoc[ch] = d[0];
      5: if (m_st[ch] == S_IDLE || m_st[ch] == S_FETCH) block_or_rearm(ch);
      6: begin m_st[ch] = S_IDLE; m_irq[ch] = 0; m_fet[ch] = 0; end
      default: ;
    endcase
  endfunction

  // Called at a falling edge; the write takes effect at the next rising edge.
  task automatic wr(input int ch, input int a, input logic [31:0] d);
    bus.wen = 1'b1; bus.wch = 2'(ch); bus.waddr = 3'(a); bus.wdata = d;
    model_write(ch, a, d);
    @(negedge clk);
    bus.wen = 1'b0;
  endtask

  task automatic cfg(input int ch, input logic [31:0] s, input logic [31:0] d, input int l,
                     input bit e, input logic [31:0] n);
    wr(ch, 0, s); wr(ch, 1, d); wr(ch, 2, 32'(l)); wr(ch, 3, n); wr(ch, 4, {31'd0, e});
    wr(ch, 5, 32'd0);
  endtask

  task automatic clr_irq(input int ch);
    bus.irq_clr = '0;
    bus.irq_clr[ch] = 1'b1;
    m_irq[ch] = 0;
    if (m_st[ch] == S_DONE) m_st[ch] = S_IDLE;
    @(negedge clk);
    bus.irq_clr = '0;
  endtask

  task automatic clear_logs();
    log_ch.delete(); log_len.delete(); log_src.delete();
  endtask

  // Acts as the burst engine and loader; every cycle compares DUT outputs with the model.
  task automatic run(input int max_cyc, input int rdy_pct, input int lat_max, input int frdy_pct,
                     input bit noise);
    int cyc;
    cyc = 0;
    forever begin
      int ch, b, ef;
      bit active;
      pend_t p;
      check("irq", 32'(bus.irq), 32'(irq_vec()));
      ef = -1;
      for (int i = NCH - 1; i >= 0; i--) if (m_st[i] == S_FETCH && !m_fet[i]) ef = i;
      check("fetch_valid", 32'(bus.fetch_valid), 32'(ef >= 0));
      if (ef >= 0) begin
        check("fetch_ch", 32'(bus.fetch_ch), 32'(ef));
        check("fetch_addr", bus.fetch_addr, m_nxt[ef]);
      end
      if (bus.req_valid) begin
        ch = int'(bus.req_ch);
        b  = exp_beats(ch);
        check("req_ch_armed", 32'(m_st[ch]), 32'(S_ARMED));
        check("req_src", bus.req_src, m_src[ch]);
        check("req_dst", bus.req_dst, m_dst[ch]);
        check("req_len", 32'(bus.req_len), 32'(b - 1));
      end
      active = pend.size() != 0;
      for (int i = 0; i < NCH; i++) if (m_st[i] == S_ARMED || m_st[i] == S_BUSY) active = 1;
      if (!active) break;
      if (cyc >= max_cyc) begin
        check("run_drained", 32'(active), 32'd0);
        break;
      end

      bus.req_ready   = ($urandom_range(0, 99) < rdy_pct);
      bus.fetch_ready = ($urandom_range(0, 99) < frdy_pct);
      bus.done_valid  = 1'b0;
      bus.irq_clr     = '0;
      if (noise) begin
        for (int i = 0; i < NCH; i++) begin
          if ($urandom_range(0, 7) == 0) begin
            bus.irq_clr[i] = 1'b1;
            m_irq[i] = 0;
            if (m_st[i] == S_DONE) m_st[i] = S_IDLE;
          end
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        ch = int'(bus.req_ch);
        b  = exp_beats(ch);
        log_ch.push_back(ch); log_len.push_back(b - 1); log_src.push_back(m_src[ch]);
        m_src[ch] = m_src[ch] + 32'(4 * b);
        m_dst[ch] = m_dst[ch] + 32'(4 * b);
        m_len[ch] = m_len[ch] - 32'(b);
        m_st[ch]  = S_BUSY;
        p.ch = ch; p.due = cyc + $urandom_range(1, lat_max);
        pend.push_back(p);
      end
      for (int k = 0; k < pend.size(); k++) begin
        if (pend[k].due <= cyc) begin
          bus.done_valid = 1'b1;
          bus.done_ch    = 2'(pend[k].ch);
          if (m_st[pend[k].ch] == S_BUSY) block_or_rearm(pend[k].ch);
          pend.delete(k);
          break;
        end
      end
      if (!bus.done_valid && noise && $urandom_range(0, 3) == 0) begin
        ch = $urandom_range(0, NCH - 1);
        if (m_st[ch] != S_BUSY) begin
          bus.done_valid = 1'b1;
          bus.done_ch    = 2'(ch);
        end
      end
      if (ef >= 0 && bus.fetch_ready) m_fet[ef] = 1;
      @(negedge clk);
      cyc++;
    end
    bus.req_ready = 1'b0; bus.done_valid = 1'b0; bus.irq_clr = '0; bus.fetch_ready = 1'b0;
    pend.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    bus.wen = 1'b0; bus.wch = '0; bus.waddr = '0; bus.wdata = '0;
    bus.req_ready = 1'b0; bus.done_valid = 1'b0; bus.done_ch = '0;
    bus.fetch_ready = 1'b0; bus.irq_clr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_valid", 32'(bus.req_valid), 32'd0);
    check("rst_req_src", bus.req_src, 32'd0);
    check("rst_req_len", 32'(bus.req_len), 32'd0);
    check("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    check("rst_irq", 32'(bus.irq), 32'd0);

    // Three bursts of a 40-word block, aligned start.
    clear_logs();
    cfg(0, 32'h1000, 32'h2000, 40, 1'b1, 32'h0);
    run(200, 100, 1, 0, 1'b0);
    check("t1_nburst", 32'(log_len.size()), 32'd3);
    if (log_len.size() == 3) begin
      check("t1_len0", 32'(log_len[0]), 32'd15);
      check("t1_len1", 32'(log_len[1]), 32'd15);
      check("t1_len2", 32'(log_len[2]), 32'd7);
      check("t1_src0", log_src[0], 32'h1000);
      check("t1_src1", log_src[1], 32'h1040);
      check("t1_src2", log_src[2], 32'h1080);
    end
    check("t1_irq0", 32'(bus.irq[0]), 32'd1);
    clr_irq(0);
    check("t1_irq0_clr", 32'(bus.irq[0]), 32'd0);

    // Source 8 bytes short of a 64-byte boundary; DST carries the same offset.
    clear_logs();
    cfg(1, 32'h1038, 32'h2038, 20, 1'b1, 32'h0);
    run(200, 100, 1, 0, 1'b0);
    check("t2_nburst", 32'(log_len.size()), 32'd3);
    if (log_len.size() == 3) begin
      check("t2_len0", 32'(log_len[0]), 32'd1);
      check("t2_len1", 32'(log_len[1]), 32'd15);
      check("t2_len2", 32'(log_len[2]), 32'd1);
    end

    // Two channels competing: grants alternate.
    clear_logs();
    cfg(0, 32'h3000, 32'h4000, 48, 1'b1, 32'h0);
    cfg(2, 32'h5000, 32'h6000, 48, 1'b1, 32'h0);
    run(300, 100, 1, 0, 1'b0);
    check("t3_ngrant", 32'(log_ch.size()), 32'd6);
    for (int k = 0; k < log_ch.size(); k++) check("t3_rr_order", 32'(log_ch[k]), 32'((k % 2) * 2));

    // Chained block: end of block without EOC requests the next descriptor.
    cfg(3, 32'h7000, 32'h7800, 4, 1'b0, 32'h8000);
    run(100, 100, 1, 0, 1'b0);
    check("t4_fetch_valid", 32'(bus.fetch_valid), 32'd1);
    check("t4_fetch_ch", 32'(bus.fetch_ch), 32'd3);
    check("t4_fetch_addr", bus.fetch_addr, 32'h8000);
    check("t4_irq3", 32'(bus.irq[3]), 32'd0);
    bus.fetch_ready = 1'b1;
    m_fet[3] = 1;
    @(negedge clk);
    bus.fetch_ready = 1'b0;
    check("t4_fetch_taken", 32'(bus.fetch_valid), 32'd0);
    wr(3, 0, 32'h9000); wr(3, 2, 32'd8); wr(3, 4, 32'd1); wr(3, 5, 32'd0);
    run(100, 100, 1, 0, 1'b0);
    check("t4_irq3_end", 32'(bus.irq[3]), 32'd1);

    // Backpressure holds the request; ABORT withdraws it.
    wr(2, 6, 32'd0);
    cfg(2, 32'h0100, 32'h0200, 32, 1'b1, 32'h0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("t5_hold_valid", 32'(bus.req_valid), 32'd1);
      check("t5_hold_ch", 32'(bus.req_ch), 32'd2);
      check("t5_hold_src", bus.req_src, 32'h0100);
      check("t5_hold_len", 32'(bus.req_len), 32'd15);
      @(negedge clk);
    end
    wr(2, 6, 32'd0);
    check("t5_abort_drop", 32'(bus.req_valid), 32'd0);
    // Abort a BUSY channel; its late completion must not re-arm it.
    wr(2, 5, 32'd0);
    @(negedge clk);
    check("t5_regrant", 32'(bus.req_valid), 32'd1);
    b = exp_beats(2);
    bus.req_ready = 1'b1;
    m_src[2] = m_src[2] + 32'(4 * b); m_dst[2] = m_dst[2] + 32'(4 * b);
    m_len[2] = m_len[2] - 32'(b); m_st[2] = S_BUSY;
    @(negedge clk);
    bus.req_ready = 1'b0;
    wr(2, 6, 32'd0);
    bus.done_valid = 1'b1; bus.done_ch = 2'd2;
    @(negedge clk);
    bus.done_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_late_done_ignored", 32'(bus.req_valid), 32'd0);
    check("t5_irq", 32'(bus.irq), 32'(irq_vec()));

    // Reset in the middle of a burst.
    wr(0, 6, 32'd0);
    cfg(0, 32'h1000, 32'h2000, 32, 1'b1, 32'h0);
    @(negedge clk);
    bus.req_ready = 1'b1;
    @(negedge clk);
    bus.req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_req_valid", 32'(bus.req_valid), 32'd0);
    check("t6_rst_req_src", bus.req_src, 32'd0);
    check("t6_rst_irq", 32'(bus.irq), 32'd0);
    check("t6_rst_fetch", 32'(bus.fetch_valid), 32'd0);
    rst = 1'b0;
    model_reset();
    bus.done_valid = 1'b1; bus.done_ch = 2'd0;
    @(negedge clk);
    bus.done_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_done_after_rst", 32'(bus.req_valid), 32'd0);
    check("t6_irq_after_rst", 32'(bus.irq), 32'd0);

    // Randomized traffic with backpressure, variable completion latency, stray completions and clears.
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < NCH; c++) begin
        logic [31:0] s, d;
        s = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFC0 + 32'(4 * $urandom_range(0, 15))
                                         : {$urandom(), 2'b00} >> 0;
        s[1:0] = 2'b00;
        d = $urandom();
        d[1:0] = 2'b00;
        wr(c, 6, 32'd0);
        cfg(c, s, d, $urandom_range(0, 40), 1'($urandom_range(0, 1)), $urandom());
      end
      run(3000, 60, 4, 50, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
